// File: rtl/filter_pkg.sv
// rtl/filter_pkg.sv - shared constants for the stereo FIR scheduler
package filter_pkg;

   localparam int DEFAULT_DATA_WIDTH = 16;

   localparam logic CH_LEFT  = 1'b0;
   localparam logic CH_RIGHT = 1'b1;

   localparam logic [2:0] ST_IDLE    = 3'd0;
   localparam logic [2:0] ST_WR_L    = 3'd1;
   localparam logic [2:0] ST_START_L = 3'd2;
   localparam logic [2:0] ST_WAIT_L  = 3'd3;
   localparam logic [2:0] ST_WR_R    = 3'd4;
   localparam logic [2:0] ST_START_R = 3'd5;
   localparam logic [2:0] ST_WAIT_R  = 3'd6;
   localparam logic [2:0] ST_PUBLISH = 3'd7;

   typedef enum logic [2:0] {
      IDLE    = ST_IDLE,
      WR_L    = ST_WR_L,
      START_L = ST_START_L,
      WAIT_L  = ST_WAIT_L,
      WR_R    = ST_WR_R,
      START_R = ST_START_R,
      WAIT_R  = ST_WAIT_R,
      PUBLISH = ST_PUBLISH
   } state_t;

endpackage

// File: rtl/sync_edge.sv
// rtl/sync_edge.sv - two-flop synchronizer with rising-edge detect
module sync_edge (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic rise
);

   logic       s1;
   logic       s2;
   logic       prev;
   logic [1:0] fill;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1   <= 1'b0;
         s2   <= 1'b0;
         prev <= 1'b0;
         fill <= 2'd0;
      end else begin
         s1   <= din;
         s2   <= s1;
         prev <= s2;
         if (fill != 2'd3)
            fill <= fill + 2'd1;
      end
   end

   // A level held high across reset release must not look like a fresh edge,
   // so detection waits until prev holds a real post-reset sample.
   assign rise = s2 & ~prev & (fill == 2'd3);

endmodule

// File: rtl/fir_scheduler.sv
// rtl/fir_scheduler.sv - time-shares one FIR engine between left and right channels
module fir_scheduler
   import filter_pkg::*;
#(
   parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
   parameter int TIMEOUT    = 255
) (
   input  logic                  main_clk,
   input  logic                  reset,
   input  logic                  sample_end,
   input  logic [DATA_WIDTH-1:0] left_in,
   input  logic [DATA_WIDTH-1:0] right_in,
   output logic                  rb_write,
   output logic                  rb_sel,
   output logic [DATA_WIDTH-1:0] rb_data,
   output logic                  fir_reset,
   output logic                  fir_chan,
   input  logic                  fir_done,
   input  logic [DATA_WIDTH-1:0] fir_result,
   output logic [DATA_WIDTH-1:0] left_out,
   output logic [DATA_WIDTH-1:0] right_out,
   output logic                  out_valid,
   output logic                  busy,
   output logic                  overrun,
   output logic                  timeout_err,
   input  logic                  err_clr
);

   localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT - 1);

   state_t                state;
   state_t                state_nxt;
   logic                  rise;
   logic [7:0]            cnt;
   logic [DATA_WIDTH-1:0] cap_l;
   logic [DATA_WIDTH-1:0] cap_r;
   logic [DATA_WIDTH-1:0] res_l;
   logic [DATA_WIDTH-1:0] res_r;
   logic [DATA_WIDTH-1:0] res_l_nxt;
   logic [DATA_WIDTH-1:0] res_r_nxt;
   logic                  expired;

   sync_edge u_sync (
      .clk  (main_clk),
      .rst  (reset),
      .din  (sample_end),
      .rise (rise)
   );

   always_ff @(posedge main_clk or posedge reset) begin
      if (reset)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   // The first WAIT cycle (cnt == 0) ignores fir_done, which may still be stale.
   always_comb begin
      state_nxt = state;
      res_l_nxt = res_l;
      res_r_nxt = res_r;
      expired   = 1'b0;
      case (state)
         IDLE:    if (rise) state_nxt = WR_L;
         WR_L:    state_nxt = START_L;
         START_L: state_nxt = WAIT_L;
         WAIT_L: begin
            if (cnt != 8'd0 && fir_done) begin
               res_l_nxt = fir_result;
               state_nxt = WR_R;
            end else if (cnt == LAST_WAIT) begin
               expired   = 1'b1;
               state_nxt = WR_R;
            end
         end
         WR_R:    state_nxt = START_R;
         START_R: state_nxt = WAIT_R;
         WAIT_R: begin
            if (cnt != 8'd0 && fir_done) begin
               res_r_nxt = fir_result;
               state_nxt = PUBLISH;
            end else if (cnt == LAST_WAIT) begin
               expired   = 1'b1;
               state_nxt = PUBLISH;
            end
         end
         PUBLISH: state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge main_clk or posedge reset) begin
      if (reset) begin
         rb_write    <= 1'b0;
         fir_reset   <= 1'b0;
         out_valid   <= 1'b0;
         cnt         <= 8'd0;
         cap_l       <= '0;
         cap_r       <= '0;
         res_l       <= '0;
         res_r       <= '0;
         left_out    <= '0;
         right_out   <= '0;
         overrun     <= 1'b0;
         timeout_err <= 1'b0;
      end else begin
         rb_write  <= (state_nxt == WR_L) || (state_nxt == WR_R);
         fir_reset <= (state_nxt == START_L) || (state_nxt == START_R);
         out_valid <= (state_nxt == PUBLISH);

         if (state == START_L || state == START_R)
            cnt <= 8'd0;
         else if (state == WAIT_L || state == WAIT_R)
            cnt <= cnt + 8'd1;

         if (state == IDLE && rise) begin
            cap_l <= left_in;
            cap_r <= right_in;
         end

         res_l <= res_l_nxt;
         res_r <= res_r_nxt;
         if (state_nxt == PUBLISH) begin
            left_out  <= res_l_nxt;
            right_out <= res_r_nxt;
         end

         if (rise && state != IDLE)
            overrun <= 1'b1;
         else if (err_clr)
            overrun <= 1'b0;

         if (expired)
            timeout_err <= 1'b1;
         else if (err_clr)
            timeout_err <= 1'b0;
      end
   end

   assign busy     = (state != IDLE);
   assign rb_sel   = (state == WR_R) ? CH_RIGHT : CH_LEFT;
   assign rb_data  = (state == WR_L) ? cap_l : (state == WR_R) ? cap_r : '0;
   assign fir_chan = (state == WR_R || state == START_R || state == WAIT_R) ? CH_RIGHT : CH_LEFT;

endmodule

// File: tb/tb_fir_scheduler.sv
// tb/tb_fir_scheduler.sv - directed self-checking bench for fir_scheduler
`timescale 1ns/1ps
module tb_fir_scheduler;

   localparam int DW = 16;

   logic          main_clk = 1'b0;
   logic          reset;
   logic          sample_end;
   logic [DW-1:0] left_in;
   logic [DW-1:0] right_in;
   logic          rb_write;
   logic          rb_sel;
   logic [DW-1:0] rb_data;
   logic          fir_reset;
   logic          fir_chan;
   logic          fir_done;
   logic [DW-1:0] fir_result;
   logic [DW-1:0] left_out;
   logic [DW-1:0] right_out;
   logic          out_valid;
   logic          busy;
   logic          overrun;
   logic          timeout_err;
   logic          err_clr;

   int total = 0;
   int bad   = 0;

   logic          model_done   = 1'b0;
   logic          man_done     = 1'b0;
   logic [DW-1:0] model_result = '0;
   logic [DW-1:0] man_result   = '0;
   logic [DW-1:0] last_l       = '0;
   logic [DW-1:0] last_r       = '0;
   bit            model_en     = 1'b1;
   bit            left_hang    = 1'b0;
   bit            model_busy   = 1'b0;
   int            model_cnt    = 0;

   assign fir_done   = model_done | man_done;
   assign fir_result = man_done ? man_result : model_result;

   always #5 main_clk = ~main_clk;

   fir_scheduler #(.DATA_WIDTH(DW), .TIMEOUT(20)) dut (
      .main_clk    (main_clk),
      .reset       (reset),
      .sample_end  (sample_end),
      .left_in     (left_in),
      .right_in    (right_in),
      .rb_write    (rb_write),
      .rb_sel      (rb_sel),
      .rb_data     (rb_data),
      .fir_reset   (fir_reset),
      .fir_chan    (fir_chan),
      .fir_done    (fir_done),
      .fir_result  (fir_result),
      .left_out    (left_out),
      .right_out   (right_out),
      .out_valid   (out_valid),
      .busy        (busy),
      .overrun     (overrun),
      .timeout_err (timeout_err),
      .err_clr     (err_clr)
   );

   // FIR engine model: done 10 cycles after fir_reset, result = written sample + 1
   initial begin
      forever begin
         @(negedge main_clk);
         if (rb_write) begin
            if (rb_sel) last_r = rb_data;
            else        last_l = rb_data;
         end
         if (fir_reset) begin
            model_done = 1'b0;
            model_cnt  = 10;
            model_busy = model_en && !(fir_chan == 1'b0 && left_hang);
         end else if (model_busy) begin
            model_cnt = model_cnt - 1;
            if (model_cnt == 0) begin
               model_done   = 1'b1;
               model_result = (fir_chan ? last_r : last_l) + 16'd1;
               model_busy   = 1'b0;
            end
         end
      end
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge main_clk);
   endtask

   task automatic check_idle(input string tag);
      check_eq({tag, "_busy"},      32'(busy),        32'h0);
      check_eq({tag, "_rb_write"},  32'(rb_write),    32'h0);
      check_eq({tag, "_rb_sel"},    32'(rb_sel),      32'h0);
      check_eq({tag, "_rb_data"},   32'(rb_data),     32'h0);
      check_eq({tag, "_fir_reset"}, 32'(fir_reset),   32'h0);
      check_eq({tag, "_fir_chan"},  32'(fir_chan),    32'h0);
      check_eq({tag, "_left_out"},  32'(left_out),    32'h0);
      check_eq({tag, "_right_out"}, 32'(right_out),   32'h0);
      check_eq({tag, "_out_valid"}, 32'(out_valid),   32'h0);
      check_eq({tag, "_overrun"},   32'(overrun),     32'h0);
      check_eq({tag, "_timeout"},   32'(timeout_err), 32'h0);
   endtask

   // Called on a negedge with sample_end low; E is two cycles after the raise.
   task automatic run_nominal(input string tag);
      left_in    = 16'h1234;
      right_in   = 16'hABCD;
      sample_end = 1'b1;
      step(2);
      check_eq({tag, "_e_no_write"}, 32'(rb_write), 32'h0);
      step(1);
      check_eq({tag, "_wl_write"}, 32'(rb_write), 32'h1);
      check_eq({tag, "_wl_sel"},   32'(rb_sel),   32'h0);
      check_eq({tag, "_wl_data"},  32'(rb_data),  32'h1234);
      step(1);
      check_eq({tag, "_sl_reset"}, 32'(fir_reset), 32'h1);
      check_eq({tag, "_sl_chan"},  32'(fir_chan),  32'h0);
      step(1);
      check_eq({tag, "_guard_reset"}, 32'(fir_reset), 32'h0);
      check_eq({tag, "_guard_busy"},  32'(busy),      32'h1);
      step(10);
      check_eq({tag, "_wr_write"}, 32'(rb_write), 32'h1);
      check_eq({tag, "_wr_sel"},   32'(rb_sel),   32'h1);
      check_eq({tag, "_wr_data"},  32'(rb_data),  32'hABCD);
      step(1);
      check_eq({tag, "_sr_reset"}, 32'(fir_reset), 32'h1);
      check_eq({tag, "_sr_chan"},  32'(fir_chan),  32'h1);
      step(10);
      check_eq({tag, "_pre_valid"}, 32'(out_valid), 32'h0);
      step(1);
      check_eq({tag, "_valid"}, 32'(out_valid), 32'h1);
      check_eq({tag, "_left"},  32'(left_out),  32'h1235);
      check_eq({tag, "_right"}, 32'(right_out), 32'hABCE);
      step(1);
      check_eq({tag, "_valid_end"}, 32'(out_valid), 32'h0);
      check_eq({tag, "_idle"},      32'(busy),      32'h0);
   endtask

   initial begin
      int n;
      reset      = 1'b1;
      sample_end = 1'b0;
      err_clr    = 1'b0;
      left_in    = '0;
      right_in   = '0;
      step(2);
      check_idle("reset");
      reset = 1'b0;
      step(4);

      run_nominal("nom");
      sample_end = 1'b0;
      step(3);

      // stale done through START_L and guard
      model_en   = 1'b0;
      left_in    = 16'h00A5;
      right_in   = 16'h00C3;
      sample_end = 1'b1;
      step(3);
      man_result = 16'hDEAD;
      man_done   = 1'b1;
      step(3);
      man_done = 1'b0;
      check_eq("stale_not_taken", 32'(rb_write), 32'h0);
      check_eq("stale_busy",      32'(busy),     32'h1);
      step(5);
      check_eq("stale_still_wait", 32'(rb_write), 32'h0);
      man_result = 16'h5555;
      man_done   = 1'b1;
      step(1);
      man_done = 1'b0;
      check_eq("stale_wr_write", 32'(rb_write), 32'h1);
      check_eq("stale_wr_data",  32'(rb_data),  32'h00C3);
      step(3);
      man_result = 16'h6666;
      man_done   = 1'b1;
      step(1);
      man_done = 1'b0;
      check_eq("stale_valid", 32'(out_valid), 32'h1);
      check_eq("stale_left",  32'(left_out),  32'h5555);
      check_eq("stale_right", 32'(right_out), 32'h6666);
      model_en   = 1'b1;
      sample_end = 1'b0;
      step(3);

      // left channel never completes
      left_hang  = 1'b1;
      left_in    = 16'h0101;
      right_in   = 16'h0202;
      sample_end = 1'b1;
      step(24);
      check_eq("to_last_wait", 32'(rb_write),    32'h0);
      check_eq("to_not_yet",   32'(timeout_err), 32'h0);
      step(1);
      check_eq("to_wr_write", 32'(rb_write),    32'h1);
      check_eq("to_wr_data",  32'(rb_data),     32'h0202);
      check_eq("to_flag",     32'(timeout_err), 32'h1);
      step(12);
      check_eq("to_valid", 32'(out_valid), 32'h1);
      check_eq("to_left",  32'(left_out),  32'h5555);
      check_eq("to_right", 32'(right_out), 32'h0203);
      left_hang  = 1'b0;
      sample_end = 1'b0;
      err_clr    = 1'b1;
      step(1);
      err_clr = 1'b0;
      check_eq("to_clr", 32'(timeout_err), 32'h0);
      step(3);

      // second edge during WAIT_R is dropped
      left_in    = 16'h1111;
      right_in   = 16'h2222;
      sample_end = 1'b1;
      step(7);
      sample_end = 1'b0;
      step(9);
      left_in    = 16'h7777;
      sample_end = 1'b1;
      step(2);
      check_eq("ovr_not_yet", 32'(overrun), 32'h0);
      step(1);
      check_eq("ovr_set", 32'(overrun), 32'h1);
      n = 0;
      for (int i = 0; i < 40; i++) begin
         step(1);
         if (out_valid) n++;
      end
      check_eq("ovr_one_valid", 32'(n),         32'd1);
      check_eq("ovr_left",      32'(left_out),  32'h1112);
      check_eq("ovr_right",     32'(right_out), 32'h2223);
      sample_end = 1'b0;
      step(3);
      err_clr = 1'b1;
      step(1);
      err_clr = 1'b0;
      check_eq("ovr_clr", 32'(overrun), 32'h0);

      // set event coincides with err_clr
      left_in    = 16'h1111;
      right_in   = 16'h2222;
      sample_end = 1'b1;
      step(3);
      sample_end = 1'b0;
      step(2);
      sample_end = 1'b1;
      step(2);
      err_clr = 1'b1;
      step(1);
      err_clr = 1'b0;
      check_eq("ovr_set_wins", 32'(overrun), 32'h1);
      sample_end = 1'b0;
      step(30);
      err_clr = 1'b1;
      step(1);
      err_clr = 1'b0;
      check_eq("ovr_clr2", 32'(overrun), 32'h0);
      step(2);

      // reset in the middle of WAIT_L with sample_end held high
      left_in    = 16'h1234;
      right_in   = 16'hABCD;
      sample_end = 1'b1;
      step(7);
      check_eq("mid_busy", 32'(busy), 32'h1);
      reset = 1'b1;
      #1;
      check_idle("mid_rst");
      step(3);
      reset = 1'b0;
      n = 0;
      for (int i = 0; i < 20; i++) begin
         step(1);
         if (busy || rb_write) n++;
      end
      check_eq("mid_no_restart", 32'(n), 32'd0);
      sample_end = 1'b0;
      step(3);
      run_nominal("post_rst");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
